// File: rtl/md5_block_packer.sv
// MD5 single-block packer: byte stream in, padded 512-bit block out.
// Optional rejected-message counter: define MD5_PACKER_ERR_CNT_EN.
module md5_block_packer #(
  parameter int unsigned MAX_LEN = 55
) (
  input  logic         ACLK,
  input  logic         ARESETN,
  input  logic [7:0]   s_tdata,
  input  logic         s_tvalid,
  input  logic         s_tlast,
  output logic         s_tready,
  output logic [511:0] m_block,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [5:0]   msg_len,
  output logic         err_ovf
`ifdef MD5_PACKER_ERR_CNT_EN
  ,
  output logic [15:0]  err_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    PAD,
    OUT,
    DRAIN
  } state_t;

  localparam logic [5:0] LAST_IDX = 6'(MAX_LEN - 1);

  state_t     state_q;
  logic [5:0] cnt_q;
  logic       s_acc;

  assign s_acc = s_tvalid & s_tready;

  // m_block doubles as the assembly buffer; it is only
  // meaningful to the consumer while m_valid is high.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      s_tready <= 1'b0;
      m_valid  <= 1'b0;
      m_block  <= '0;
      msg_len  <= '0;
      err_ovf  <= 1'b0;
    end else begin
      err_ovf <= 1'b0;
      unique case (state_q)
        IDLE: begin
          state_q  <= COLLECT;
          s_tready <= 1'b1;
        end
        COLLECT: begin
          if (s_acc) begin
            m_block[{cnt_q, 3'b000} +: 8] <= s_tdata;
            cnt_q <= cnt_q + 6'd1;
            if (s_tlast) begin
              state_q  <= PAD;
              s_tready <= 1'b0;
            end else if (cnt_q == LAST_IDX) begin
              state_q <= DRAIN;
              err_ovf <= 1'b1;
            end
          end
        end
        PAD: begin
          m_block[{cnt_q, 3'b000} +: 8] <= 8'h80;
          m_block[511:448] <= {55'd0, cnt_q, 3'b000};
          msg_len <= cnt_q;
          m_valid <= 1'b1;
          state_q <= OUT;
        end
        OUT: begin
          if (m_ready) begin
            m_valid  <= 1'b0;
            m_block  <= '0;
            cnt_q    <= '0;
            msg_len  <= '0;
            s_tready <= 1'b1;
            state_q  <= COLLECT;
          end
        end
        DRAIN: begin
          if (s_acc && s_tlast) begin
            m_block <= '0;
            cnt_q   <= '0;
            state_q <= COLLECT;
          end
        end
        default: begin
          state_q  <= IDLE;
          s_tready <= 1'b0;
          m_valid  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MD5_PACKER_ERR_CNT_EN
  // Saturating; steps on the same edge that raises err_ovf.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      err_cnt <= '0;
    end else if (state_q == COLLECT && s_acc && !s_tlast
                 && cnt_q == LAST_IDX && err_cnt != 16'hFFFF) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_md5_block_packer.sv
// Testbench for md5_block_packer: spec vectors, corner sequences
// and random messages against a padding reference model.
module tb_md5_block_packer;

  logic         ACLK = 1'b0;
  logic         ARESETN;
  logic [7:0]   s_tdata;
  logic         s_tvalid;
  logic         s_tlast;
  logic         s_tready;
  logic [511:0] m_block;
  logic         m_valid;
  logic         m_ready;
  logic [5:0]   msg_len;
  logic         err_ovf;
`ifdef MD5_PACKER_ERR_CNT_EN
  logic [15:0]  err_cnt;
`endif

  md5_block_packer #(.MAX_LEN(55)) dut (
    .ACLK     (ACLK),
    .ARESETN  (ARESETN),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_block  (m_block),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .msg_len  (msg_len),
    .err_ovf  (err_ovf)
`ifdef MD5_PACKER_ERR_CNT_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    int          len;
    logic [7:0]  data [64];
    int          stall;
    bit          chk_w;
    logic [31:0] w0;
    logic [31:0] w13;
    logic [31:0] w14;
    logic [31:0] w15;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int ovf_pulses = 0;
  int mv_cycles  = 0;
  int stall_cnt  = 0;
  int err_exp    = 0;

  always @(negedge ACLK) begin
    if (err_ovf === 1'b1) ovf_pulses++;
    if (m_valid === 1'b1) mv_cycles++;
  end

  task automatic check(input string name,
                       input logic [511:0] got,
                       input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input int len, input logic [7:0] base,
                              input logic [7:0] step, input int stall);
    vec_t v;
    v.len = len;
    v.stall = stall;
    v.chk_w = 1'b0;
    v.w0 = '0; v.w13 = '0; v.w14 = '0; v.w15 = '0;
    for (int i = 0; i < 64; i++) v.data[i] = base + 8'(i) * step;
    return v;
  endfunction

  function automatic vec_t with_words(input vec_t v, input logic [31:0] w0,
                                      input logic [31:0] w13,
                                      input logic [31:0] w14,
                                      input logic [31:0] w15);
    vec_t r = v;
    r.chk_w = 1'b1;
    r.w0 = w0; r.w13 = w13; r.w14 = w14; r.w15 = w15;
    return r;
  endfunction

  // MD5 padding rule: message, 0x80, zeros, 64-bit LE bit length
  function automatic logic [511:0] model(input vec_t v);
    logic [511:0] b = '0;
    for (int i = 0; i < v.len; i++) b[i*8 +: 8] = v.data[i];
    b[v.len*8 +: 8] = 8'h80;
    b[511:448] = 64'(v.len * 8);
    return b;
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic last);
    int w = 0;
    s_tdata = d; s_tvalid = 1'b1; s_tlast = last;
    @(negedge ACLK);
    while (s_tready !== 1'b1 && w < 100) begin
      w++; stall_cnt++;
      @(negedge ACLK);
    end
    if (s_tready !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: s_tready %b required 1", s_tready);
    end
    @(posedge ACLK); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic run_vec(input string name, input vec_t v);
    logic [511:0] exp;
    logic [511:0] held;
    int p0, m0;
    bit ovf;
    ovf = (v.len > 55);
    p0 = ovf_pulses; m0 = mv_cycles; stall_cnt = 0;
    m_ready = (v.stall == 0);
    for (int i = 0; i < v.len; i++) send_byte(v.data[i], i == v.len - 1);
    check({name, "_no_stall"}, 512'(stall_cnt), 512'd0);
    if (ovf) begin
      check({name, "_ovf_rdy"}, 512'(s_tready), 512'd1);
      @(posedge ACLK); #1;
      check({name, "_ovf_pulse"}, 512'(ovf_pulses - p0), 512'd1);
      check({name, "_ovf_nomv"}, 512'(mv_cycles - m0), 512'd0);
      err_exp++;
`ifdef MD5_PACKER_ERR_CNT_EN
      check({name, "_err_cnt"}, 512'(err_cnt), 512'(err_exp));
`endif
      m_ready = 1'b0;
      return;
    end
    exp = model(v);
    check({name, "_pad_mv"}, 512'(m_valid), 512'd0);
    @(posedge ACLK); #1;
    check({name, "_mv"}, 512'(m_valid), 512'd1);
    check({name, "_block"}, m_block, exp);
    check({name, "_len"}, 512'(msg_len), 512'(v.len));
    if (v.chk_w) begin
      check({name, "_w0"}, 512'(m_block[31:0]), 512'(v.w0));
      check({name, "_w13"}, 512'(m_block[447:416]), 512'(v.w13));
      check({name, "_w14"}, 512'(m_block[479:448]), 512'(v.w14));
      check({name, "_w15"}, 512'(m_block[511:480]), 512'(v.w15));
    end
    held = m_block;
    if (v.stall > 0) begin
      s_tdata = 8'hEE; s_tvalid = 1'b1; s_tlast = 1'b1;
      for (int c = 0; c < v.stall; c++) begin
        @(posedge ACLK); #1;
        check({name, "_bp_block"}, m_block, held);
        check({name, "_bp_mv"}, 512'(m_valid), 512'd1);
        check({name, "_bp_rdy"}, 512'(s_tready), 512'd0);
      end
      s_tvalid = 1'b0; s_tlast = 1'b0;
      m_ready = 1'b1;
    end
    @(posedge ACLK); #1;
    m_ready = 1'b0;
    check({name, "_hs_mv"}, 512'(m_valid), 512'd0);
    check({name, "_hs_rdy"}, 512'(s_tready), 512'd1);
    check({name, "_ovf_none"}, 512'(ovf_pulses - p0), 512'd0);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_rdy"}, 512'(s_tready), 512'd0);
    check({name, "_mv"}, 512'(m_valid), 512'd0);
    check({name, "_ovf"}, 512'(err_ovf), 512'd0);
    check({name, "_block"}, m_block, 512'd0);
    check({name, "_len"}, 512'(msg_len), 512'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [6];
    vec_t rv;
    string nm [6];
    ARESETN = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_ready = 1'b0;

    nm[0] = "abc";
    tbl[0] = with_words(mk(3, 8'h61, 8'd1, 0),
                        32'h80636261, 32'h0, 32'h18, 32'h0);
    nm[1] = "max55";
    tbl[1] = with_words(mk(55, 8'h41, 8'd0, 0),
                        32'h41414141, 32'h80414141, 32'h1B8, 32'h0);
    nm[2] = "ovf60";
    tbl[2] = mk(60, 8'h30, 8'd1, 0);
    nm[3] = "a_after";
    tbl[3] = with_words(mk(1, 8'h61, 8'd0, 0),
                        32'h00008061, 32'h0, 32'h8, 32'h0);
    nm[4] = "zero1";
    tbl[4] = with_words(mk(1, 8'h00, 8'd0, 0),
                        32'h00008000, 32'h0, 32'h8, 32'h0);
    nm[5] = "bp10";
    tbl[5] = with_words(mk(3, 8'h61, 8'd1, 10),
                        32'h80636261, 32'h0, 32'h18, 32'h0);

    repeat (3) @(posedge ACLK);
    #1;
    check_reset_vals("reset");
`ifdef MD5_PACKER_ERR_CNT_EN
    check("reset_err_cnt", 512'(err_cnt), 512'd0);
`endif
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    check("collect_rdy", 512'(s_tready), 512'd1);

    for (int t = 0; t < 6; t++) run_vec(nm[t], tbl[t]);

    // mid-message reset discards the partial message
    for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), 1'b0);
    #3 ARESETN = 1'b0;
    #1;
    check_reset_vals("mid_reset");
`ifdef MD5_PACKER_ERR_CNT_EN
    err_exp = 0;
    check("mid_reset_err_cnt", 512'(err_cnt), 512'd0);
`endif
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    run_vec("abc_post_reset", tbl[0]);

    // 56-byte message: tlast lands in the first drain cycle
    run_vec("ovf56", mk(56, 8'h10, 8'd3, 0));
    run_vec("after56", tbl[4]);

    for (int r = 0; r < 25; r++) begin
      rv = mk($urandom_range(60, 1), 8'h00, 8'd0, 0);
      for (int i = 0; i < 64; i++) rv.data[i] = 8'($urandom);
      if ($urandom_range(9, 0) < 3) rv.stall = $urandom_range(4, 1);
      run_vec($sformatf("rand%0d", r), rv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
